vector_point_sequencer: RTL and testbench

- Parametrised successor to the single-channel DAC test driver.
- Accepts a stream of (x, y, blank) vector points through a valid/ready handshake and buffers them in a small synchronous FIFO.
- For each point it issues two ordered strobed writes (X on axis 0, Y on axis 1) to the dual-channel DAC driver, updates the beam-blank output, then dwells a programmable number of cycles.
- Sits between the line generator / point source and the mcp4922 DAC driver.

---
 rtl/vector_point_sequencer_pkg.sv | 18 +
 rtl/vector_point_sequencer_fifo.sv | 60 ++++++
 rtl/vector_point_sequencer.sv | 150 +++++++++++++++
 tb/tb_vector_point_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_point_sequencer_pkg.sv
// Shared types for the vector point sequencer and its point FIFO.
// A point travels as the flat word {blank, y, x}, 2*WIDTH+1 bits wide.
package vector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_X,
    ST_GAP_X,
    ST_SEND_Y,
    ST_GAP_Y,
    ST_DWELL
  } state_e;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

endpackage

// File: rtl/vector_point_sequencer_fifo.sv
// Synchronous point FIFO with registered read data, sized to a power of two.
// Also intended for reuse by the line generator.
module point_fifo #(
  parameter int WIDTH_DATA = 25,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH_DATA-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [WIDTH_DATA-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic [WIDTH_DATA-1:0] rd_data_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = rd_data_q;

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vector_point_sequencer.sv
// Buffers (x, y, blank) points and plays each one out as an X then Y DAC write,
// updating beam blank on the Y write and dwelling before the next point.
//
// state   | meaning
// IDLE    | waiting for a buffered point; pops the head when one exists
// LOAD    | FIFO read data settles; captured into working registers
// SEND_X  | waits for dac_ready, then strobes the X value on axis 0
// GAP_X   | strobe low; dac_ready ignored while the driver reacts
// SEND_Y  | waits for dac_ready, then strobes Y on axis 1 and applies blank
// GAP_Y   | strobe low; dwell counter loaded
// DWELL   | counts down the dwell; leaves at a count of 1
module vector_point_sequencer
  import vector_pkg::*;
#(
  parameter int WIDTH        = 12,
  parameter int DEPTH        = 8,
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pt_valid,
  input  logic [WIDTH-1:0] pt_x,
  input  logic [WIDTH-1:0] pt_y,
  input  logic             pt_blank,
  output logic             pt_ready,
  output logic [WIDTH-1:0] dac_value,
  output logic             dac_axis,
  output logic             dac_strobe,
  input  logic             dac_ready,
  output logic             blank,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PW   = 2 * WIDTH + 1;
  localparam int DW_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             pt_blank_q, pt_blank_d;
  logic [WIDTH-1:0] dac_value_q, dac_value_d;
  logic             dac_axis_q, dac_axis_d;
  logic             dac_strobe_q, dac_strobe_d;
  logic             blank_q, blank_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  logic [PW-1:0]    fifo_rd_data;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  point_fifo #(
    .WIDTH_DATA (PW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (pt_valid),
    .wr_data_i ({pt_blank, pt_y, pt_x}),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign pt_ready   = !fifo_full;
  assign busy       = (state_q != ST_IDLE);
  assign dac_value  = dac_value_q;
  assign dac_axis   = dac_axis_q;
  assign dac_strobe = dac_strobe_q;
  assign blank      = blank_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SEND_X;
      ST_SEND_X: if (dac_ready) state_d = ST_GAP_X;
      ST_GAP_X:  state_d = ST_SEND_Y;
      ST_SEND_Y: if (dac_ready) state_d = ST_GAP_Y;
      ST_GAP_Y:  state_d = (DWELL_CYCLES == 0) ? ST_IDLE : ST_DWELL;
      ST_DWELL:  if (dwell_q == DW_W'(1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobe defaults low so it can never be high two cycles running.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    pt_blank_d   = pt_blank_q;
    dac_value_d  = dac_value_q;
    dac_axis_d   = dac_axis_q;
    dac_strobe_d = 1'b0;
    blank_d      = blank_q;
    dwell_d      = dwell_q;
    case (state_q)
      ST_LOAD: {pt_blank_d, y_d, x_d} = fifo_rd_data;
      ST_SEND_X: begin
        if (dac_ready) begin
          dac_value_d  = x_q;
          dac_axis_d   = AXIS_X;
          dac_strobe_d = 1'b1;
        end
      end
      ST_SEND_Y: begin
        if (dac_ready) begin
          dac_value_d  = y_q;
          dac_axis_d   = AXIS_Y;
          dac_strobe_d = 1'b1;
          blank_d      = pt_blank_q;
        end
      end
      ST_GAP_Y: dwell_d = DW_W'(DWELL_CYCLES);
      ST_DWELL: dwell_d = dwell_q - DW_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      pt_blank_q   <= 1'b1;
      dac_value_q  <= '0;
      dac_axis_q   <= AXIS_X;
      dac_strobe_q <= 1'b0;
      blank_q      <= 1'b1;
      dwell_q      <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      pt_blank_q   <= pt_blank_d;
      dac_value_q  <= dac_value_d;
      dac_axis_q   <= dac_axis_d;
      dac_strobe_q <= dac_strobe_d;
      blank_q      <= blank_d;
      dwell_q      <= dwell_d;
    end
  end

endmodule

// File: tb/tb_vector_point_sequencer.sv
// Bench for vector_point_sequencer: directed steps with random point data,
// checked against a point-level scoreboard of expected DAC writes.
module tb_vector_point_sequencer;

  localparam int W  = 12;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          pt_valid, pt_blank, pt_ready;
  logic [W-1:0]  pt_x, pt_y, dac_value;
  logic          dac_axis, dac_strobe, dac_ready, blank, busy;
  logic [CW-1:0] fifo_count;

  logic          b_pt_valid, b_pt_blank, b_pt_ready;
  logic [W-1:0]  b_pt_x, b_pt_y, b_dac_value;
  logic          b_dac_axis, b_dac_strobe, b_dac_ready, b_blank, b_busy;
  logic [CW-1:0] b_fifo_count;

  vector_point_sequencer #(.WIDTH(W), .DEPTH(D), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y),
    .pt_blank(pt_blank), .pt_ready(pt_ready), .dac_value(dac_value),
    .dac_axis(dac_axis), .dac_strobe(dac_strobe), .dac_ready(dac_ready),
    .blank(blank), .busy(busy), .fifo_count(fifo_count)
  );

  vector_point_sequencer #(.WIDTH(W), .DEPTH(D), .DWELL_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .pt_valid(b_pt_valid), .pt_x(b_pt_x), .pt_y(b_pt_y),
    .pt_blank(b_pt_blank), .pt_ready(b_pt_ready), .dac_value(b_dac_value),
    .dac_axis(b_dac_axis), .dac_strobe(b_dac_strobe), .dac_ready(b_dac_ready),
    .blank(b_blank), .busy(b_busy), .fifo_count(b_fifo_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted point owes an X write then a Y write.
  typedef struct {
    logic [W-1:0] v;
    logic         ax;
    logic         bl;
  } exp_t;
  exp_t exp_q[$];
  int   strobe_cnt = 0;
  int   last_x_cyc = 0;
  int   last_y_cyc = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (dac_strobe === 1'b1) begin
      chk("strobe_back_to_back", prev_strobe, 0);
      strobe_cnt++;
      chk("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_value", dac_value, e.v);
        chk("strobe_axis", dac_axis, e.ax);
        if (e.ax) begin
          chk("blank_on_y", blank, e.bl);
          last_y_cyc = cyc;
        end else begin
          last_x_cyc = cyc;
        end
      end
    end
    prev_strobe = dac_strobe;
  end

  // DAC driver stand-in: forced level, or auto mode that drops ready on each strobe.
  logic dac_auto  = 1'b0;
  logic dac_level = 1'b1;
  initial begin : dac_emu
    logic s;
    int   hold;
    hold = 0;
    dac_ready = 1'b1;
    forever begin
      @(negedge clk);
      s = dac_strobe;
      @(posedge clk);
      #1;
      if (!dac_auto) dac_ready = dac_level;
      else if (s) begin
        dac_ready = 1'b0;
        hold = $urandom_range(0, 3);
      end else if (hold > 0) hold--;
      else dac_ready = 1'b1;
    end
  end

  logic [W-1:0] bx_q[$];
  int           bxc_q[$];
  always @(negedge clk) begin
    if (b_dac_strobe === 1'b1 && b_dac_axis === 1'b0) begin
      bxc_q.push_back(cyc);
      chk("b_x_expected", bx_q.size() != 0, 1);
      if (bx_q.size() != 0) chk("b_x_value", b_dac_value, bx_q.pop_front());
    end
  end

  int push_cyc = 0;
  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
    int t;
    t = 0;
    @(negedge clk);
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_blank = b;
    while (pt_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (pt_ready !== 1'b1) begin
      chk("push_timeout", pt_ready, 1);
      pt_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    push_cyc = cyc;
    pt_valid = 1'b0;
    exp_q.push_back('{x, 1'b0, b});
    exp_q.push_back('{y, 1'b1, b});
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, sc0, t;
    logic [W-1:0] bx, by;
    logic phase2;

    reset = 1'b1;
    pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_blank = 1'b0;
    b_pt_valid = 1'b0; b_pt_x = '0; b_pt_y = '0; b_pt_blank = 1'b0;
    b_dac_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pt_ready", pt_ready, 1);
    chk("rst_dac_value", dac_value, 0);
    chk("rst_dac_axis", dac_axis, 0);
    chk("rst_dac_strobe", dac_strobe, 0);
    chk("rst_blank", blank, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_b_count", b_fifo_count, 0);
    chk("rst_b_blank", b_blank, 1);

    // Single point: X at +3, Y at +5, busy for the 10-cycle point period.
    push(12'd15, 12'd10, 1'b0);
    p = push_cyc;
    repeat (12) begin
      @(negedge clk);
      chk("single_busy", busy, (cyc - p >= 1) && (cyc - p <= 9));
      if (cyc - p == 4) chk("single_blank_before_y", blank, 1);
    end
    chk("single_x_latency", last_x_cyc - p, 3);
    chk("single_y_latency", last_y_cyc - p, 5);
    chk("single_blank_after", blank, 0);
    wait_drain("single");

    // Fill with the DAC stalled: one point parks in the FSM, DEPTH more buffer.
    dac_level = 1'b0;
    @(negedge clk);
    for (int i = 0; i < D + 1; i++) push(W'($urandom), W'($urandom), 1'($urandom));
    @(negedge clk);
    chk("fill_ready_low", pt_ready, 0);
    chk("fill_count", fifo_count, D);
    fork
      push(W'($urandom), W'($urandom), 1'($urandom));
      begin
        repeat (5) begin
          @(negedge clk);
          chk("fill_held_ready", pt_ready, 0);
          chk("fill_held_count", fifo_count, D);
        end
        dac_auto = 1'b1;
      end
    join
    wait_drain("fill");
    dac_auto = 1'b0;
    dac_level = 1'b1;
    @(negedge clk);

    // DAC backpressure in SEND_Y: X value must hold, one Y strobe afterwards.
    bx = W'($urandom); by = W'($urandom);
    sc0 = strobe_cnt;
    push(bx, by, 1'b1);
    t = 0;
    while (dac_strobe !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_x_strobe_seen", dac_strobe, 1);
    dac_level = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dac_strobe !== 1'b0 || dac_value !== bx || dac_axis !== 1'b0) begin
        chk("bp_stall_strobe", dac_strobe, 0);
        chk("bp_stall_value", dac_value, bx);
        chk("bp_stall_axis", dac_axis, 0);
      end else n_vec++;
    end
    dac_level = 1'b1;
    wait_drain("bp");
    chk("bp_strobe_total", strobe_cnt - sc0, 2);

    // Wrap-around stream under random DAC busy time.
    dac_auto = 1'b1;
    sc0 = strobe_cnt;
    for (int i = 0; i < 20; i++) push(W'(i), W'(100 + i), 1'($urandom));
    wait_drain("wrap");
    chk("wrap_strobe_total", strobe_cnt - sc0, 40);
    dac_auto = 1'b0;
    dac_level = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while dwelling with three points queued.
    push(W'($urandom), W'($urandom), 1'b0);
    p = push_cyc;
    for (int i = 0; i < 3; i++) push(W'($urandom), W'($urandom), 1'($urandom));
    while (cyc < p + 7) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_count", fifo_count, 3);
    chk("mid_blank", blank, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_blank", blank, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_strobe", dac_strobe, 0);
    chk("mid_rst_ready", pt_ready, 1);
    push(W'($urandom), W'($urandom), 1'($urandom));
    p = push_cyc;
    repeat (6) @(negedge clk);
    chk("mid_fresh_x_latency", last_x_cyc - p, 3);
    wait_drain("mid");

    // Zero dwell: hold the count at 4 by pushing only on pop cycles.
    phase2 = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!phase2 && b_fifo_count == CW'(4)) phase2 = 1'b1;
      if (phase2) begin
        chk("b_count_steady", b_fifo_count, 4);
        b_pt_valid = (b_busy == 1'b0);
      end else begin
        b_pt_valid = 1'b1;
      end
      b_pt_x = W'($urandom); b_pt_y = W'($urandom); b_pt_blank = 1'($urandom);
      if (b_pt_valid && b_pt_ready) bx_q.push_back(b_pt_x);
    end
    b_pt_valid = 1'b0;
    chk("b_reached_four", phase2, 1);
    chk("b_enough_points", bxc_q.size() >= 8, 1);
    for (int i = 1; i < bxc_q.size(); i++) chk("b_period", bxc_q[i] - bxc_q[i-1], 6);

    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
